// File: rtl/ising_run_ctrl_pkg.sv
// Shared register map, CTRL bit positions and FSM encodings for the Ising
// anneal-run controller.
package ising_run_ctrl_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_SETTLE = 2'd1;
    localparam logic [1:0] REG_RUN    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_ABORT_BIT    = 1;
    localparam int CTRL_CLR_DONE_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_SAMPLE = 2'd3
    } run_state_e;

    // One-shot commands decoded from a single CTRL write.
    typedef struct packed {
        logic start;
        logic abort;
        logic clr_done;
    } ctrl_cmd_t;

    function automatic logic [31:0] pack_status(input logic        busy,
                                                input logic        done,
                                                input logic        aborted,
                                                input logic [15:0] runs);
        return {runs, 13'd0, aborted, done, busy};
    endfunction

endpackage

// File: rtl/ising_run_ctrl_if.sv
// Register-slice bus between the AXI write/read front end and the run controller.
interface ising_run_ctrl_if;

    // Handshake: a write is taken on any clk edge where wready && wr_addr_match
    // (no back-pressure, the slave always accepts); rdata is a combinational
    // decode of rd_offset and is valid in the same cycle.
    logic        wready;
    logic        wr_addr_match;
    logic [1:0]  wr_offset;
    logic [31:0] wdata;
    logic [1:0]  rd_offset;
    logic [31:0] rdata;

    modport master (
        output wready,
        output wr_addr_match,
        output wr_offset,
        output wdata,
        output rd_offset,
        input  rdata
    );

    modport slave (
        input  wready,
        input  wr_addr_match,
        input  wr_offset,
        input  wdata,
        input  rd_offset,
        output rdata
    );

endinterface

// File: rtl/ising_run_counter.sv
// Loadable down-counter shared by the settle and run phases; at_one_o flags
// the last cycle of the current phase.
module ising_run_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             at_one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ising_run_ctrl.sv
// Sequences one anneal run: hold the array in reset while spins settle, release
// it for run_len cycles, strobe the samplers, then return to reset.
module ising_run_ctrl
    import ising_run_ctrl_pkg::*;
#(
    parameter int CNT_W  = 24,
    parameter int RUNS_W = 16
) (
    input  logic              clk,
    input  logic              axi_rstn,
    ising_run_ctrl_if.slave   bus,
    output logic              ising_rstn,
    output logic              sample_en,
    output logic              busy,
    output logic              done,
    output run_state_e        state_dbg
);

    run_state_e        state_q;
    logic              ising_rstn_q;
    logic              sample_en_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic [RUNS_W-1:0] run_count_q;
    logic [CNT_W-1:0]  settle_len_q;
    logic [CNT_W-1:0]  run_len_q;

    logic              wr_en;
    logic [CNT_W-1:0]  wr_len;
    ctrl_cmd_t         cmd;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_at_one;

    logic              unused_wdata;

    assign wr_en  = bus.wready & bus.wr_addr_match;
    // A zero length would never reach at_one, so it is stored as 1.
    assign wr_len = (bus.wdata[CNT_W-1:0] == '0) ? CNT_W'(1) : bus.wdata[CNT_W-1:0];
    assign unused_wdata = ^{1'b0, bus.wdata};

    always_comb begin
        cmd = '0;
        if (wr_en && (bus.wr_offset == REG_CTRL)) begin
            cmd.abort    = bus.wdata[CTRL_ABORT_BIT];
            cmd.start    = bus.wdata[CTRL_START_BIT] & ~bus.wdata[CTRL_ABORT_BIT];
            cmd.clr_done = bus.wdata[CTRL_CLR_DONE_BIT];
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            settle_len_q <= CNT_W'(1);
            run_len_q    <= CNT_W'(1);
        end else if (wr_en && !busy_q) begin
            case (bus.wr_offset)
                REG_SETTLE: settle_len_q <= wr_len;
                REG_RUN:    run_len_q    <= wr_len;
                default:    ;
            endcase
        end
    end

    // The counter is loaded with settle_len on START and reloaded with run_len
    // on the last settle cycle, so both phases dwell exactly their length.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = settle_len_q;
        cnt_en       = 1'b0;
        case (state_q)
            ST_IDLE: cnt_load = cmd.start;
            ST_SETTLE: begin
                if (cnt_at_one) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = run_len_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RUN:  cnt_en = 1'b1;
            default: ;
        endcase
    end

    ising_run_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (axi_rstn),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .at_one_o   (cnt_at_one)
    );

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q      <= ST_IDLE;
            ising_rstn_q <= 1'b0;
            sample_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            run_count_q  <= '0;
        end else begin
            sample_en_q <= 1'b0;
            if (cmd.clr_done) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end
            if (cmd.abort && (state_q != ST_IDLE)) begin
                state_q      <= ST_IDLE;
                ising_rstn_q <= 1'b0;
                busy_q       <= 1'b0;
                aborted_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd.start) begin
                            state_q   <= ST_SETTLE;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            aborted_q <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_at_one) begin
                            state_q      <= ST_RUN;
                            ising_rstn_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (cnt_at_one) begin
                            state_q     <= ST_SAMPLE;
                            sample_en_q <= 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        state_q      <= ST_IDLE;
                        ising_rstn_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        run_count_q  <= run_count_q + RUNS_W'(1);
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.rd_offset)
            REG_SETTLE: bus.rdata = 32'(settle_len_q);
            REG_RUN:    bus.rdata = 32'(run_len_q);
            REG_STATUS: bus.rdata = pack_status(busy_q, done_q, aborted_q, 16'(run_count_q));
            default:    bus.rdata = '0;
        endcase
    end

    assign ising_rstn = ising_rstn_q;
    assign sample_en  = sample_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Scoreboard bench for ising_run_ctrl: a cycle-arithmetic model predicts each
// sample strobe and every register read.
module tb_ising_run_ctrl;
    import ising_run_ctrl_pkg::*;

    localparam int CNT_W    = 24;
    localparam int RUNS_W   = 2;
    localparam int CLK_HALF = 5;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       axi_rstn = 1'b1;
    logic       ising_rstn;
    logic       sample_en;
    logic       busy;
    logic       done;
    run_state_e state_dbg;
    int         cyc = 0;

    ising_run_ctrl_if bus ();

    ising_run_ctrl #(
        .CNT_W  (CNT_W),
        .RUNS_W (RUNS_W)
    ) dut (
        .clk        (clk),
        .axi_rstn   (axi_rstn),
        .bus        (bus),
        .ising_rstn (ising_rstn),
        .sample_en  (sample_en),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    always #CLK_HALF clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Each entry: {cycle index of the sample strobe, ising_rstn high cycles up to and including it}
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_settle, m_run, m_runs, m_end, last_edge;
    bit m_done, m_aborted, m_active;

    function automatic void model_reset();
        m_settle  = 1;
        m_run     = 1;
        m_runs    = 0;
        m_end     = 0;
        m_done    = 1'b0;
        m_aborted = 1'b0;
        m_active  = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_complete();
        m_active = 1'b0;
        m_done   = 1'b1;
        m_runs++;
    endfunction

    // A run started on edge t is busy for writes landing on edges t+1 .. t+s+r+1.
    function automatic void model_write(input logic [1:0] off, input logic [31:0] data, input int e);
        int len;
        bit busy_now;
        if (m_active && e > m_end) model_complete();
        busy_now = m_active;
        len = int'(data & ((32'd1 << CNT_W) - 32'd1));
        if (len == 0) len = 1;
        case (off)
            2'd0: begin
                if (data[2]) begin
                    m_done    = 1'b0;
                    m_aborted = 1'b0;
                end
                if (data[1]) begin
                    if (busy_now) begin
                        if (e < m_end && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
                        m_active  = 1'b0;
                        m_aborted = 1'b1;
                    end
                end else if (data[0] && !busy_now) begin
                    m_active  = 1'b1;
                    m_done    = 1'b0;
                    m_aborted = 1'b0;
                    m_end     = e + m_settle + m_run + 1;
                    exp_q.push_back({32'(e + m_settle + m_run), 32'(m_run + 1)});
                end
            end
            2'd1: if (!busy_now) m_settle = len;
            2'd2: if (!busy_now) m_run = len;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] off, input int c);
        if (m_active && c >= m_end) model_complete();
        case (off)
            2'd1:    return 32'(m_settle);
            2'd2:    return 32'(m_run);
            2'd3:    return {16'(m_runs % (1 << RUNS_W)), 13'd0, m_aborted, m_done, m_active};
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- monitor ----------------
    int hi_cnt = 0;
    bit post_sample = 1'b0;

    always @(negedge clk) begin
        logic [63:0] ent;
        if (post_sample) begin
            check("rstn_after_sample", 32'(ising_rstn), 32'd0);
            post_sample = 1'b0;
        end
        if (ising_rstn) hi_cnt++;
        else hi_cnt = 0;
        if (sample_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'(sample_en), 32'd0);
            end else begin
                ent = exp_q.pop_front();
                check("sample_cycle", 32'(cyc), ent[63:32]);
                check("rstn_high_cycles", 32'(hi_cnt), ent[31:0]);
            end
            post_sample = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input bit match);
        @(negedge clk);
        bus.wready        = 1'b1;
        bus.wr_addr_match = match;
        bus.wr_offset     = off;
        bus.wdata         = data;
        @(posedge clk);
        #1;
        bus.wready        = 1'b0;
        bus.wr_addr_match = 1'b0;
        last_edge         = cyc;
        if (match) model_write(off, data, cyc);
    endtask

    task automatic read_check(input logic [1:0] off, input string name);
        logic [31:0] exp;
        @(negedge clk);
        bus.rd_offset = off;
        #1;
        exp = model_read(off, cyc);
        check(name, bus.rdata, exp);
        if (off == REG_STATUS) begin
            check({name, "_busy_pin"}, 32'(busy), 32'(exp[0]));
            check({name, "_done_pin"}, 32'(done), 32'(exp[1]));
        end
    endtask

    task automatic start_run(input int s, input int r);
        bus_write(REG_SETTLE, 32'(s), 1'b1);
        bus_write(REG_RUN, 32'(r), 1'b1);
        bus_write(REG_CTRL, 32'h1, 1'b1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t, s, r, d;
        bus.wready        = 1'b0;
        bus.wr_addr_match = 1'b0;
        bus.wr_offset     = 2'd0;
        bus.wdata         = 32'd0;
        bus.rd_offset     = 2'd0;
        model_reset();

        #1 axi_rstn = 1'b0;
        #1;
        check("reset_ising_rstn", 32'(ising_rstn), 32'd0);
        check("reset_sample_en", 32'(sample_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        axi_rstn = 1'b1;
        read_check(REG_CTRL, "reset_ctrl");
        read_check(REG_SETTLE, "reset_settle");
        read_check(REG_RUN, "reset_run");
        read_check(REG_STATUS, "reset_status");

        // write outside the window is ignored
        bus_write(REG_SETTLE, 32'd9, 1'b0);
        read_check(REG_SETTLE, "nomatch_settle");

        // basic run
        start_run(3, 5);
        wait_drain(60, "basic_drain");
        read_check(REG_STATUS, "basic_status");
        check("basic_status_const", bus.rdata, 32'h0001_0002);

        // zero lengths stored as 1
        bus_write(REG_SETTLE, 32'd0, 1'b1);
        bus_write(REG_RUN, 32'h0100_0000, 1'b1);
        read_check(REG_SETTLE, "zero_settle");
        read_check(REG_RUN, "zero_run");
        bus_write(REG_CTRL, 32'h1, 1'b1);
        wait_drain(20, "zero_drain");
        read_check(REG_STATUS, "zero_status");

        // busy protection and abort mid-run
        start_run(2, 100);
        t = last_edge;
        repeat (3) @(posedge clk);
        bus_write(REG_RUN, 32'd7, 1'b1);
        bus_write(REG_CTRL, 32'h1, 1'b1);
        read_check(REG_RUN, "busy_run_len");
        while (cyc < t + 11) @(posedge clk);
        bus_write(REG_CTRL, 32'h2, 1'b1);
        @(negedge clk);
        check("abort_ising_rstn", 32'(ising_rstn), 32'd0);
        check("abort_sample_en", 32'(sample_en), 32'd0);
        repeat (5) @(negedge clk);
        wait_drain(5, "abort_drain");
        read_check(REG_STATUS, "abort_status");
        read_check(REG_RUN, "abort_run_len");

        // START|ABORT together in IDLE does nothing
        bus_write(REG_CTRL, 32'h3, 1'b1);
        @(negedge clk);
        check("idle_start_abort_busy", 32'(busy), 32'd0);
        read_check(REG_STATUS, "idle_start_abort_status");

        // three more runs: completed count reaches 5 and wraps
        for (int i = 0; i < 3; i++) begin
            start_run($urandom_range(0, 4), $urandom_range(0, 6));
            wait_drain(40, "wrap_drain");
            read_check(REG_STATUS, "wrap_status");
        end
        bus_write(REG_CTRL, 32'h4, 1'b1);
        read_check(REG_STATUS, "clr_done_status");

        // randomized runs with optional abort (possibly with CLR_DONE)
        for (int i = 0; i < 10; i++) begin
            s = $urandom_range(0, 6);
            r = $urandom_range(0, 8);
            start_run(s, r);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom_range(0, m_settle + m_run);
                repeat (d) @(posedge clk);
                bus_write(REG_CTRL, ($urandom_range(0, 1) == 1) ? 32'h6 : 32'h2, 1'b1);
            end
            wait_drain(40, "rand_drain");
            read_check(REG_STATUS, "rand_status");
            if ($urandom_range(0, 2) == 0) begin
                bus_write(REG_CTRL, 32'h4, 1'b1);
                read_check(REG_STATUS, "rand_clr_status");
            end
        end

        // asynchronous reset between edges during RUN
        start_run(2, 20);
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1 axi_rstn = 1'b0;
        #1;
        check("areset_ising_rstn", 32'(ising_rstn), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_done", 32'(done), 32'd0);
        model_reset();
        bus.rd_offset = REG_STATUS;
        #1 check("areset_status", bus.rdata, model_read(REG_STATUS, cyc));
        bus.rd_offset = REG_RUN;
        #1 check("areset_run_len", bus.rdata, model_read(REG_RUN, cyc));
        @(negedge clk);
        axi_rstn = 1'b1;

        // recovery run after reset
        start_run(1, 2);
        wait_drain(20, "recover_drain");
        read_check(REG_STATUS, "recover_status");

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
